// File: rtl/nexys_video_axil_manager.sv
// AXI-Lite manager: turns one valid/ready command into an AW/W/B or AR/R transaction and returns the response.
// Latency: with a zero-wait subordinate the response is valid 3 cycles after command accept (4-cycle issue interval).
// Backpressure: one transaction in flight; the response is held until i_rsp_ready. Optional watchdog: AXIL_MGR_TIMEOUT_EN.
module nexys_video_axil_manager #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int unsigned AXI_RESP_WIDTH = 2,
  parameter int unsigned MGR_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  // command port
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] i_cmd_wstrb,
  // response port
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [AXI_RESP_WIDTH-1:0] o_rsp_resp,
  output logic                      o_timeout,
  // write address channel
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [AXI_ID_WIDTH-1:0]   o_awid,
  output logic [AXI_ADDR_WIDTH-1:0] o_awaddr,
  output logic [2:0]                o_awprot,
  // write data channel
  output logic                      o_wvalid,
  input  logic                      i_wready,
  output logic [AXI_DATA_WIDTH-1:0] o_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_wstrb,
  // write response channel
  input  logic                      i_bvalid,
  output logic                      o_bready,
  input  logic [AXI_ID_WIDTH-1:0]   i_bid,
  input  logic [AXI_RESP_WIDTH-1:0] i_bresp,
  // read address channel
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [AXI_ID_WIDTH-1:0]   o_arid,
  output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
  output logic [2:0]                o_arprot,
  // read data channel
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_ID_WIDTH-1:0]   i_rid,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [AXI_RESP_WIDTH-1:0] i_rresp
);

  localparam logic [AXI_ID_WIDTH-1:0]   ID_VAL = AXI_ID_WIDTH'(MGR_ID);
  localparam logic [AXI_RESP_WIDTH-1:0] SLVERR = AXI_RESP_WIDTH'(2);

`ifdef AXIL_MGR_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP, S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_RSP
  } state_t;
`endif

  state_t                    state;
  logic                      cmd_ready_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      rsp_valid_q;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q;
  logic [AXI_RESP_WIDTH-1:0] rsp_resp_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q;

  // A channel counts as done once its valid has dropped or is handshaking now
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid_q || i_awready;
  assign w_done  = !wvalid_q || i_wready;

`ifdef AXIL_MGR_TIMEOUT_EN
  localparam logic [AXI_RESP_WIDTH-1:0] DECERR = AXI_RESP_WIDTH'(3);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q;
  logic          timeout_q;
  logic          timed_out_q;   // current response was substituted, clean-up needed afterwards
  logic          wr_q;          // direction of the in-flight command
  logic          pend_b_q;      // abandoned write still owes a B beat
  logic          pend_r_q;      // abandoned read still owes an R beat
  logic          active;
  logic          done_now;
  logic          expire;

  // Whether the waiting state completes normally this cycle (normal completion beats the watchdog)
  always_comb begin
    done_now = 1'b0;
    case (state)
      S_WR_REQ:  done_now = aw_done && w_done;
      S_WR_RESP: done_now = i_bvalid;
      S_RD_REQ:  done_now = i_arready;
      S_RD_DATA: done_now = i_rvalid;
      default:   done_now = 1'b0;
    endcase
  end

  assign active = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                  (state == S_RD_REQ) || (state == S_RD_DATA);
  assign expire = active && !done_now && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Transaction sequencer; every handshake output is a registered flop
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
`ifdef AXIL_MGR_TIMEOUT_EN
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
      wr_q        <= 1'b0;
      pend_b_q    <= 1'b0;
      pend_r_q    <= 1'b0;
`endif
    end else begin
`ifdef AXIL_MGR_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            addr_q      <= i_cmd_addr;
            wdata_q     <= i_cmd_wdata;
            wstrb_q     <= i_cmd_wstrb;
            cmd_ready_q <= 1'b0;
`ifdef AXIL_MGR_TIMEOUT_EN
            timer_q     <= '0;
            wr_q        <= i_cmd_write;
`endif
            if (i_cmd_write) begin
              state     <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= S_RD_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (awvalid_q && i_awready) awvalid_q <= 1'b0;
          if (wvalid_q && i_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state    <= S_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (i_bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= (i_bid != ID_VAL) ? SLVERR : i_bresp;
            state       <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (i_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= i_rdata;
            rsp_resp_q  <= (i_rid != ID_VAL) ? SLVERR : i_rresp;
            state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
`ifdef AXIL_MGR_TIMEOUT_EN
            if (timed_out_q) begin
              state       <= S_DRAIN;
              cmd_ready_q <= 1'b0;
            end
`endif
          end
        end
`ifdef AXIL_MGR_TIMEOUT_EN
        S_DRAIN: begin
          if (!awvalid_q && !wvalid_q && !arvalid_q && !pend_b_q && !pend_r_q) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            timed_out_q <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase

`ifdef AXIL_MGR_TIMEOUT_EN
      // Watchdog: substitute DECERR, keep unfinished valids up, and remember which beat is owed
      if (expire) begin
        state       <= S_RSP;
        rsp_valid_q <= 1'b1;
        rsp_resp_q  <= DECERR;
        rsp_rdata_q <= '0;
        timeout_q   <= 1'b1;
        timed_out_q <= 1'b1;
        if (wr_q) begin
          bready_q <= 1'b1;
          pend_b_q <= 1'b1;
        end else begin
          rready_q <= 1'b1;
          pend_r_q <= 1'b1;
        end
      end else if (active) begin
        timer_q <= timer_q + TW'(1);
      end

      // After a timeout, finish stranded handshakes and swallow the late response
      if (state == S_RSP || state == S_DRAIN) begin
        if (awvalid_q && i_awready) awvalid_q <= 1'b0;
        if (wvalid_q && i_wready)   wvalid_q  <= 1'b0;
        if (arvalid_q && i_arready) arvalid_q <= 1'b0;
        if (pend_b_q && i_bvalid) begin
          pend_b_q <= 1'b0;
          bready_q <= 1'b0;
        end
        if (pend_r_q && i_rvalid) begin
          pend_r_q <= 1'b0;
          rready_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
`ifdef AXIL_MGR_TIMEOUT_EN
  assign o_timeout   = timeout_q;
`else
  assign o_timeout   = 1'b0;
`endif

  assign o_awvalid = awvalid_q;
  assign o_awid    = ID_VAL;
  assign o_awaddr  = addr_q;
  assign o_awprot  = 3'b000;
  assign o_wvalid  = wvalid_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_bready  = bready_q;
  assign o_arvalid = arvalid_q;
  assign o_arid    = ID_VAL;
  assign o_araddr  = addr_q;
  assign o_arprot  = 3'b000;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_nexys_video_axil_manager.sv
// Testbench for nexys_video_axil_manager: directed transactions against a cycle-timeline model.
// Latency: the model predicts every output per cycle from handshake arithmetic.
// Backpressure: exercised via delayed readies/valids and held response-ready.
`timescale 1ns/1ps
module tb_nexys_video_axil_manager;

  logic        aclk = 1'b0;
  logic        areset;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [63:0] i_cmd_addr, i_cmd_wdata;
  logic [7:0]  i_cmd_wstrb;
  logic        o_rsp_valid, i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic        o_timeout;
  logic        o_awvalid, i_awready;
  logic [0:0]  o_awid;
  logic [63:0] o_awaddr;
  logic [2:0]  o_awprot;
  logic        o_wvalid, i_wready;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        i_bvalid, o_bready;
  logic [0:0]  i_bid;
  logic [1:0]  i_bresp;
  logic        o_arvalid, i_arready;
  logic [0:0]  o_arid;
  logic [63:0] o_araddr;
  logic [2:0]  o_arprot;
  logic        i_rvalid, o_rready;
  logic [0:0]  i_rid;
  logic [63:0] i_rdata;
  logic [1:0]  i_rresp;

  always #5 aclk = ~aclk;

  nexys_video_axil_manager #(
    .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_STRB_WIDTH(8),
    .AXI_RESP_WIDTH(2), .MGR_ID(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_timeout(o_timeout),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_arid(o_arid), .o_araddr(o_araddr), .o_arprot(o_arprot),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model of the current transaction (cycle numbers of each handshake)
  bit          chk_en = 1'b0;
  bit          m_act  = 1'b0;
  bit          m_wr;
  int          m_t0, m_taw, m_tw, m_treq, m_tb, m_trh;
  logic [63:0] m_addr, m_wdata, m_rdata_exp;
  logic [7:0]  m_strb;
  logic [1:0]  m_resp_exp;
  logic        e_cr, e_aw, e_w, e_b, e_ar, e_r, e_rv;

  // Per-cycle comparison of every output against the timeline
  always @(negedge aclk) begin
    if (chk_en) begin
      e_cr = 1'b1; e_aw = 1'b0; e_w = 1'b0; e_b = 1'b0; e_ar = 1'b0; e_r = 1'b0; e_rv = 1'b0;
      if (m_act) begin
        e_cr = !(cyc > m_t0 && cyc <= m_trh);
        e_rv = (cyc > m_tb && cyc <= m_trh);
        if (m_wr) begin
          e_aw = (cyc > m_t0 && cyc <= m_taw);
          e_w  = (cyc > m_t0 && cyc <= m_tw);
          e_b  = (cyc > m_treq && cyc <= m_tb);
        end else begin
          e_ar = (cyc > m_t0 && cyc <= m_taw);
          e_r  = (cyc > m_taw && cyc <= m_tb);
        end
      end
      chk("cmd_ready", o_cmd_ready, e_cr);
      chk("awvalid", o_awvalid, e_aw);
      chk("wvalid", o_wvalid, e_w);
      chk("bready", o_bready, e_b);
      chk("arvalid", o_arvalid, e_ar);
      chk("rready", o_rready, e_r);
      chk("rsp_valid", o_rsp_valid, e_rv);
      chk("timeout", o_timeout, 0);
      if (e_aw) begin
        chk("awaddr", o_awaddr, m_addr);
        chk("awid", o_awid, 0);
        chk("awprot", o_awprot, 0);
      end
      if (e_w) begin
        chk("wdata", o_wdata, m_wdata);
        chk("wstrb", o_wstrb, m_strb);
      end
      if (e_ar) begin
        chk("araddr", o_araddr, m_addr);
        chk("arid", o_arid, 0);
        chk("arprot", o_arprot, 0);
      end
      if (e_rv) begin
        chk("rsp_rdata", o_rsp_rdata, m_rdata_exp);
        chk("rsp_resp", o_rsp_resp, m_resp_exp);
      end
    end
  end

  // Observation counters used by the literal expectations
  int          mon_aw, mon_w, mon_bhs, mon_rv, mon_lat;
  bit          rv_seen;
  logic [63:0] cap_rdata;
  logic [1:0]  cap_resp;
  always @(negedge aclk) begin
    if (o_awvalid) mon_aw++;
    if (o_wvalid) mon_w++;
    if (o_bready && i_bvalid) mon_bhs++;
    if (o_rsp_valid) begin
      mon_rv++;
      if (!rv_seen) begin
        rv_seen   = 1'b1;
        mon_lat   = cyc - m_t0;
        cap_rdata = o_rsp_rdata;
        cap_resp  = o_rsp_resp;
      end
    end
  end

  task automatic drive_idle();
    i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
    i_rsp_ready = 0; i_awready = 0; i_wready = 0; i_bvalid = 0; i_bid = 0; i_bresp = 0;
    i_arready = 0; i_rvalid = 0; i_rid = 0; i_rdata = 0; i_rresp = 0;
  endtask

  // da: AW/AR ready delay, dw: W ready delay, db: B/R valid delay after bready/rready, stall: rsp_ready low cycles
  task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, input int da, input int dw, input int db,
                         input int stall, input logic id, input logic [1:0] resp,
                         input logic [63:0] rdata);
    @(posedge aclk); #1;
    m_wr        = wr;
    m_t0        = cyc;
    m_taw       = cyc + 1 + da;
    m_tw        = wr ? cyc + 1 + dw : m_taw;
    m_treq      = (m_taw > m_tw) ? m_taw : m_tw;
    m_tb        = m_treq + 1 + db;
    m_trh       = m_tb + 1 + stall;
    m_addr      = addr;
    m_wdata     = wdata;
    m_strb      = strb;
    m_rdata_exp = wr ? 64'h0 : rdata;
    m_resp_exp  = (id != 1'b0) ? 2'b10 : resp;
    m_act       = 1'b1;
    mon_aw = 0; mon_w = 0; mon_bhs = 0; mon_rv = 0; mon_lat = -1; rv_seen = 1'b0;
    forever begin
      i_cmd_valid = (cyc == m_t0);
      i_cmd_write = wr;
      i_cmd_addr  = (cyc == m_t0) ? addr : ~addr;
      i_cmd_wdata = (cyc == m_t0) ? wdata : ~wdata;
      i_cmd_wstrb = (cyc == m_t0) ? strb : ~strb;
      i_awready   = wr && (cyc == m_taw);
      i_wready    = wr && (cyc == m_tw);
      i_bvalid    = wr && (cyc == m_tb);
      i_bid       = id;
      i_bresp     = (cyc == m_tb) ? resp : ~resp;
      i_arready   = !wr && (cyc == m_taw);
      i_rvalid    = !wr && (cyc == m_tb);
      i_rid       = id;
      i_rresp     = (cyc == m_tb) ? resp : ~resp;
      i_rdata     = (cyc == m_tb) ? rdata : ~rdata;
      i_rsp_ready = (cyc == m_trh);
      if (cyc == m_trh) break;
      @(posedge aclk); #1;
    end
  endtask

  int  t0;
  int  to_cyc;
  bit  got;

  initial begin
    #100000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    drive_idle();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_cmd_ready", o_cmd_ready, 1);
    chk("reset_awvalid", o_awvalid, 0);
    chk("reset_wvalid", o_wvalid, 0);
    chk("reset_arvalid", o_arvalid, 0);
    chk("reset_bready", o_bready, 0);
    chk("reset_rready", o_rready, 0);
    chk("reset_rsp_valid", o_rsp_valid, 0);
    chk("reset_rsp_rdata", o_rsp_rdata, 0);
    chk("reset_rsp_resp", o_rsp_resp, 0);
    chk("reset_timeout", o_timeout, 0);
    chk("reset_awaddr", o_awaddr, 0);
    chk("reset_wdata", o_wdata, 0);
    areset = 1'b0;
    chk_en = 1'b1;

    // zero-wait write 0x1 to 0x0
    run_txn(1, 64'h0, 64'h1, 8'hFF, 0, 0, 0, 0, 1'b0, 2'b00, 64'h0);
    @(negedge aclk); #1;
    chk("t1_rsp_latency", mon_lat, 3);
    chk("t1_resp", cap_resp, 2'b00);
    chk("t1_aw_cycles", mon_aw, 1);
    chk("t1_rdata_zero", cap_rdata, 0);

    // AW ready delayed 3 cycles, W immediate, B two cycles late
    run_txn(1, 64'h18, 64'hDEADBEEF00C0FFEE, 8'h0F, 3, 0, 2, 0, 1'b0, 2'b00, 64'h0);
    @(negedge aclk); #1;
    chk("t2_aw_cycles", mon_aw, 4);
    chk("t2_w_cycles", mon_w, 1);
    chk("t2_b_handshakes", mon_bhs, 1);
    chk("t2_resp", cap_resp, 2'b00);

    // read 0x8 -> 0xA5, response held for 5 stalled cycles
    run_txn(0, 64'h8, 64'h0, 8'h0, 0, 0, 0, 5, 1'b0, 2'b00, 64'hA5);
    @(negedge aclk); #1;
    chk("t3_rsp_cycles", mon_rv, 6);
    chk("t3_rdata", cap_rdata, 64'hA5);
    chk("t3_rsp_latency", mon_lat, 3);
    @(posedge aclk); #1; drive_idle();
    @(negedge aclk);
    chk("t3_cmd_ready_after", o_cmd_ready, 1);

    // wrong RID forces SLVERR
    run_txn(0, 64'h30, 64'h0, 8'h0, 1, 0, 1, 0, 1'b1, 2'b00, 64'h1234);
    @(negedge aclk); #1;
    chk("t4_rid_slverr", cap_resp, 2'b10);

    // wrong BID with EXOKAY still reports SLVERR
    run_txn(1, 64'h38, 64'h77, 8'h81, 0, 0, 0, 0, 1'b1, 2'b01, 64'h0);
    @(negedge aclk); #1;
    chk("t5_bid_slverr", cap_resp, 2'b10);

    // W later than AW, both late together, read error passthrough, back-to-back zero-wait pair
    run_txn(1, 64'h100, 64'h5555, 8'hF0, 0, 2, 1, 0, 1'b0, 2'b00, 64'h0);
    run_txn(1, 64'h108, 64'hAAAA, 8'h3C, 2, 2, 0, 1, 1'b0, 2'b11, 64'h0);
    run_txn(0, 64'h110, 64'h0, 8'h0, 2, 0, 3, 1, 1'b0, 2'b10, 64'hCAFE);
    run_txn(0, 64'h118, 64'h0, 8'h0, 0, 0, 0, 0, 1'b0, 2'b00, 64'h0123456789ABCDEF);
    t0 = m_t0;
    run_txn(1, 64'h120, 64'h42, 8'hFF, 0, 0, 0, 0, 1'b0, 2'b00, 64'h0);
    chk("t6_issue_interval", m_t0 - t0, 4);
    @(negedge aclk); #1;
    chk("t6_rsp_latency", mon_lat, 3);

    // reset while in RD_DATA
    chk_en = 1'b0;
    @(posedge aclk); #1; drive_idle();
    i_cmd_valid = 1; i_cmd_addr = 64'h40;
    @(posedge aclk); #1; drive_idle();
    i_arready = 1;
    chk("rst_pre_arvalid", o_arvalid, 1);
    @(posedge aclk); #1; drive_idle();
    chk("rst_pre_rready", o_rready, 1);
    #2 areset = 1'b1;
    #1;
    chk("rst_mid_cmd_ready", o_cmd_ready, 1);
    chk("rst_mid_rready", o_rready, 0);
    chk("rst_mid_arvalid", o_arvalid, 0);
    chk("rst_mid_araddr", o_araddr, 0);
    chk("rst_mid_rsp_valid", o_rsp_valid, 0);
    @(negedge aclk); areset = 1'b0;
    @(posedge aclk); #1;
    chk("rst_after_cmd_ready", o_cmd_ready, 1);
    chk("rst_after_rsp_valid", o_rsp_valid, 0);
    chk_en = 1'b1;
    run_txn(0, 64'h48, 64'h0, 8'h0, 0, 0, 0, 0, 1'b0, 2'b00, 64'h99);
    @(negedge aclk); #1;
    chk("rst_recover_rdata", cap_rdata, 64'h99);

`ifdef AXIL_MGR_TIMEOUT_EN
    // write whose B never arrives; late B must be swallowed
    chk_en = 1'b0;
    @(posedge aclk); #1; drive_idle();
    t0 = cyc;
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 64'h20; i_cmd_wdata = 64'h5; i_cmd_wstrb = 8'hFF;
    @(posedge aclk); #1; drive_idle();
    i_awready = 1; i_wready = 1;
    @(posedge aclk); #1; drive_idle();
    to_cyc = -1;
    for (int k = 0; k < 40 && to_cyc < 0; k++) begin
      @(negedge aclk);
      if (o_timeout) begin
        to_cyc = cyc;
        chk("to_rsp_valid", o_rsp_valid, 1);
        chk("to_rsp_resp", o_rsp_resp, 2'b11);
        chk("to_rsp_rdata", o_rsp_rdata, 0);
      end
    end
    chk("to_cycle", to_cyc - t0, 17);
    i_rsp_ready = 1;
    @(posedge aclk); #1; i_rsp_ready = 0;
    chk("to_pulse_width", o_timeout, 0);
    chk("to_drain_cmd_ready", o_cmd_ready, 0);
    chk("to_drain_bready", o_bready, 1);
    @(posedge aclk); #1;
    i_bvalid = 1;
    @(posedge aclk); #1; i_bvalid = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge aclk);
      chk("to_no_second_rsp", o_rsp_valid, 0);
      if (o_cmd_ready) got = 1'b1;
    end
    chk("to_back_to_idle", got, 1);
    chk("to_bready_dropped", o_bready, 0);
    chk_en = 1'b1;
    run_txn(1, 64'h28, 64'h6, 8'hFF, 0, 0, 0, 0, 1'b0, 2'b00, 64'h0);
    @(negedge aclk); #1;
    chk("to_recover_latency", mon_lat, 3);
`endif

    @(posedge aclk); #1; drive_idle();
    repeat (3) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nexys_video_axil_manager.md
# nexys_video_axil_manager

AXI-Lite manager (initiator) that converts single-beat commands from a simple valid/ready command port into AXI-Lite write or read transactions and returns the response on a valid/ready response port. It is the counterpart of the basic-IO subordinate core. It sits between a host-side controller (e.g. a UART command parser or a test sequencer) and the subordinate's AXI channels. One transaction is in flight at a time.

## Interface
Parameters:
- AXI_ID_WIDTH, 1, width of AWID/ARID/BID/RID
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width
- AXI_RESP_WIDTH, 2, response width
- MGR_ID, 0, constant ID driven on AWID/ARID
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the timeout macro; must be ≥ 2

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  AXI_ADDR_WIDTH  target address
- i_cmd_wdata  in  AXI_DATA_WIDTH  write data
- i_cmd_wstrb  in  AXI_STRB_WIDTH  write strobes
- o_rsp_valid / i_rsp_ready  out/in  1  response handshake
- o_rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes
- o_rsp_resp  out  AXI_RESP_WIDTH  BRESP/RRESP or substituted error code
- o_timeout  out  1  one-cycle pulse on watchdog expiry
- AXI-Lite manager channels (names mirror the subordinate, directions reversed): o_awvalid, i_awready, o_awid, o_awaddr, o_awprot; o_wvalid, i_wready, o_wdata, o_wstrb; i_bvalid, o_bready, i_bid, i_bresp; o_arvalid, i_arready, o_arid, o_araddr, o_arprot; i_rvalid, o_rready, i_rid, i_rdata, i_rresp

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP, DRAIN.
- IDLE: o_cmd_ready = 1. On i_cmd_valid, the command fields are registered. Next state is WR_REQ if i_cmd_write, otherwise RD_REQ.
- WR_REQ: o_awvalid and o_wvalid rise together. Each one drops in the cycle after its own handshake. AW and W may complete in either order or in the same cycle. When both are done, go to WR_RESP.
- WR_RESP: o_bready = 1. On i_bvalid, capture i_bresp and go to RSP.
- RD_REQ: o_arvalid = 1 until the AR handshake, then go to RD_DATA.
- RD_DATA: o_rready = 1. On i_rvalid, capture i_rdata and i_rresp and go to RSP.
- ID check: if i_bid/i_rid ≠ MGR_ID, o_rsp_resp = 2'b10 (SLVERR) regardless of the returned response.
- RSP: o_rsp_valid = 1 and is held stable until i_rsp_ready. After the handshake, go to IDLE.
- Fixed values: AWPROT/ARPROT = 3'b000. AWID/ARID = MGR_ID. AXI address/data outputs hold the registered command for the whole transaction.
- AXI valids never depend combinationally on AXI readies.
- DRAIN is reachable only with the timeout macro enabled.

## Timing
- Reset values: state IDLE, o_cmd_ready 1, all AXI valids 0, o_bready 0, o_rready 0, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_resp 0, o_timeout 0, all registered address/data 0.
- Reset mid-transaction: everything returns to the reset values immediately. The in-flight command is lost and no response is produced.
- Zero-wait subordinate, write: command accepted at cycle 0; AW/W valid at cycle 1; bready at cycle 2; o_rsp_valid at cycle 3.
- Zero-wait subordinate, read: AR valid at cycle 1; rready at cycle 2; o_rsp_valid at cycle 3.
- o_cmd_ready returns 1 in the cycle after the response handshake. Back-to-back issue interval is 4 cycles minimum.
- Backpressure on i_rsp_ready stalls indefinitely; no new command is accepted during the stall.

## Configuration
- AXIL_MGR_TIMEOUT_EN defined:
  - A counter clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - On reaching TIMEOUT_CYCLES: o_timeout pulses for 1 cycle and the FSM enters RSP with o_rsp_resp = 2'b11 (DECERR) and o_rsp_rdata = 0.
  - Any AXI valids that have not yet handshaken stay asserted; this is an AXI stability requirement.
  - After the response handshake, the FSM enters DRAIN instead of IDLE. DRAIN completes the outstanding handshakes, holds o_bready or o_rready at 1, discards the late response, then returns to IDLE.
  - o_cmd_ready = 0 in DRAIN.
- AXIL_MGR_TIMEOUT_EN undefined: no counter and no DRAIN state; o_timeout is tied to 0; the FSM waits forever.

## Test plan
- Write 0x1 to addr 0x0, wstrb 0xFF, zero-wait subordinate: AW/W valid at cycle 1 with awaddr 0x0, wdata 0x1; o_rsp_valid at cycle 3 with resp 2'b00.
- Write with i_awready delayed 3 cycles and i_wready immediate: o_wvalid drops after 1 cycle, o_awvalid is held 4 cycles, exactly one B handshake, resp 2'b00.
- Read addr 0x8 returning rdata 0xA5, rresp 2'b00, with i_rsp_ready low for 5 cycles: o_rsp_valid and rdata 0xA5 held stable for 5 cycles, then o_cmd_ready = 1 on the next cycle.
- Read returning i_rid = 1 with MGR_ID = 0: o_rsp_resp = 2'b10.
- With the macro and TIMEOUT_CYCLES = 16, subordinate never asserts i_bvalid: o_timeout pulses, resp 2'b11. Then i_bvalid arrives: it is discarded and the FSM returns to IDLE.
- Assert areset while in RD_DATA: all outputs at reset values in the same cycle; o_cmd_ready = 1 after release.
